// File: rtl/vga_timing_gen_if.sv
// Bundle of VGA timing outputs shared between the timing generator (master)
// and its consumers such as the pixel generator and DAC (slave).
interface vga_timing_gen_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       active;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic       frame_start;
  logic       vblank_start;

  modport master (
    output hcount, vcount, active, vga_hs, vga_vs, vga_blank_n,
           vga_sync_n, frame_start, vblank_start
  );

  modport slave (
    input  hcount, vcount, active, vga_hs, vga_vs, vga_blank_n,
           vga_sync_n, frame_start, vblank_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters, undelayed decodes,
// and sync/blank outputs delayed to line up with a PIPE_DELAY-deep pixel path.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  logic active_raw;
  logic hs_raw;
  logic vs_raw;

  // vsync depends only on vcount, so it naturally changes only at hcount=0.
  assign active_raw = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hs_raw     = !((hcnt_q >= HS_BEGIN) && (hcnt_q < HS_END));
  assign vs_raw     = !((vcnt_q >= VS_BEGIN) && (vcnt_q < VS_END));

  assign vga.hcount       = hcnt_q;
  assign vga.vcount       = vcnt_q;
  assign vga.active       = active_raw;
  assign vga.vga_sync_n   = 1'b0;
  assign vga.frame_start  = (hcnt_q == '0) && (vcnt_q == '0);
  assign vga.vblank_start = (hcnt_q == '0) && (vcnt_q == V_ACT);

  if (PIPE_DELAY == 0) begin : g_nopipe
    assign vga.vga_hs      = hs_raw;
    assign vga.vga_vs      = vs_raw;
    assign vga.vga_blank_n = active_raw;
  end else begin : g_pipe
    logic [PIPE_DELAY-1:0] hs_q;
    logic [PIPE_DELAY-1:0] vs_q;
    logic [PIPE_DELAY-1:0] bn_q;

    always_ff @(posedge vga_clk) begin
      if (reset) begin
        hs_q <= '1;
        vs_q <= '1;
        bn_q <= '0;
      end else begin
        hs_q[0] <= hs_raw;
        vs_q[0] <= vs_raw;
        bn_q[0] <= active_raw;
        for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
          hs_q[i] <= hs_q[i-1];
          vs_q[i] <= vs_q[i-1];
          bn_q[i] <= bn_q[i-1];
        end
      end
    end

    assign vga.vga_hs      = hs_q[PIPE_DELAY-1];
    assign vga.vga_vs      = vs_q[PIPE_DELAY-1];
    assign vga.vga_blank_n = bn_q[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480 with delay 1, and a
// small raster with delays 0 and 3) compared every cycle against an arithmetic model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    int d;
  } cfg_t;

  typedef struct {
    int h, v;
    int act, hs, vs, bn, fs, vbs;
  } exp_t;

  localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 4;
  localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #20 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen #(.PIPE_DELAY(1)) u_a (
    .vga_clk (clk),
    .reset   (rst),
    .vga     (if_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .PIPE_DELAY(0)
  ) u_b (
    .vga_clk (clk),
    .reset   (rst),
    .vga     (if_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .PIPE_DELAY(3)
  ) u_c (
    .vga_clk (clk),
    .reset   (rst),
    .vga     (if_c)
  );

  cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
  cfg_t cfg_b = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 0};
  cfg_t cfg_c = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 3};

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Expected outputs k cycles after the last reset edge, straight from the raster rules.
  function automatic exp_t model(input cfg_t c, input int kk);
    exp_t e;
    int ht, vt, j, hj, vj;
    ht    = c.ha + c.hf + c.hs + c.hb;
    vt    = c.va + c.vf + c.vs + c.vb;
    e.h   = kk % ht;
    e.v   = (kk / ht) % vt;
    e.act = (e.h < c.ha && e.v < c.va) ? 1 : 0;
    e.fs  = (e.h == 0 && e.v == 0) ? 1 : 0;
    e.vbs = (e.h == 0 && e.v == c.va) ? 1 : 0;
    j = kk - c.d;
    if (j < 0) begin
      e.hs = 1;
      e.vs = 1;
      e.bn = 0;
    end else begin
      hj   = j % ht;
      vj   = (j / ht) % vt;
      e.hs = (hj >= c.ha + c.hf && hj < c.ha + c.hf + c.hs) ? 0 : 1;
      e.vs = (vj >= c.va + c.vf && vj < c.va + c.vf + c.vs) ? 0 : 1;
      e.bn = (hj < c.ha && vj < c.va) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic check_dut(input string nm, input cfg_t c,
                           input logic [9:0] h, input logic [9:0] v,
                           input logic act, input logic hs, input logic vs,
                           input logic bn, input logic sn, input logic fs,
                           input logic vbs);
    exp_t e;
    e = model(c, k);
    check({nm, ".hcount"},       int'(h),   e.h);
    check({nm, ".vcount"},       int'(v),   e.v);
    check({nm, ".active"},       int'(act), e.act);
    check({nm, ".vga_hs"},       int'(hs),  e.hs);
    check({nm, ".vga_vs"},       int'(vs),  e.vs);
    check({nm, ".vga_blank_n"},  int'(bn),  e.bn);
    check({nm, ".vga_sync_n"},   int'(sn),  0);
    check({nm, ".frame_start"},  int'(fs),  e.fs);
    check({nm, ".vblank_start"}, int'(vbs), e.vbs);
  endtask

  task automatic check_all();
    check_dut("a", cfg_a, if_a.hcount, if_a.vcount, if_a.active, if_a.vga_hs,
              if_a.vga_vs, if_a.vga_blank_n, if_a.vga_sync_n, if_a.frame_start,
              if_a.vblank_start);
    check_dut("b", cfg_b, if_b.hcount, if_b.vcount, if_b.active, if_b.vga_hs,
              if_b.vga_vs, if_b.vga_blank_n, if_b.vga_sync_n, if_b.frame_start,
              if_b.vblank_start);
    check_dut("c", cfg_c, if_c.hcount, if_c.vcount, if_c.active, if_c.vga_hs,
              if_c.vga_vs, if_c.vga_blank_n, if_c.vga_sync_n, if_c.frame_start,
              if_c.vblank_start);
  endtask

  // Drive reset for the next edge, advance the model at the edge, check mid-cycle.
  task automatic cycle(input logic r);
    rst = r;
    @(posedge clk);
    if (rst) k = 0;
    else     k++;
    @(negedge clk);
    check_all();
  endtask

  int hs_low = 0, hs_first = -1, bn_hi = 0, bn_first = -1;
  int vs_low_c = 0, fs_c = 0, vbs_c = 0, fs_b = 0;

  task automatic tally();
    if (k < 800) begin
      if (!if_a.vga_hs) begin
        if (hs_first < 0) hs_first = int'(if_a.hcount);
        hs_low++;
      end
      if (if_a.vga_blank_n) begin
        if (bn_first < 0) bn_first = int'(if_a.hcount);
        bn_hi++;
      end
    end
    if (k < 475) begin
      if (!if_c.vga_vs) vs_low_c++;
      if (if_c.frame_start) fs_c++;
      if (if_c.vblank_start) vbs_c++;
    end
    if (k <= 475 && if_b.frame_start) fs_b++;
  endtask

  initial begin
    int len, rl;
    @(negedge clk);
    repeat (3) cycle(1'b1);
    tally();
    for (int n = 0; n < 2000; n++) begin
      cycle(1'b0);
      tally();
    end
    check("a.hs_low_cycles",   hs_low,   96);
    check("a.hs_first_hcount", hs_first, 657);
    check("a.bn_high_cycles",  bn_hi,    640);
    check("a.bn_first_hcount", bn_first, 1);
    check("c.vs_low_frame",    vs_low_c, S_VS * (S_HA + S_HF + S_HS + S_HB));
    check("c.frame_starts",    fs_c,     1);
    check("c.vblank_starts",   vbs_c,    1);
    check("b.frame_starts_2",  fs_b,     2);

    for (int s = 0; s < 10; s++) begin
      len = int'($urandom_range(30, 2500));
      repeat (len) cycle(1'b0);
      rl = int'($urandom_range(1, 4));
      repeat (rl) cycle(1'b1);
    end
    repeat (30) cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
